load_store_unit: RTL and testbench

- Multi-cycle load/store unit between the core's execute stage (ALU address, rd2 store data, decoder memory size) and a word-wide data memory port with variable latency.
- Formats byte/half/word accesses into word address, byte enables and replicated write data.
- Extracts and sign/zero-extends load data.
- Holds the core with a stall (the inverse of the PC-update enable) until the access completes, times out or faults.

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: formats B/H/W accesses onto a word-wide memory port
// and extends load data. Define MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  core_req_i,
   input  logic                  core_we_i,
   input  logic [2:0]            core_size_i,
   input  logic [ADDR_WIDTH-1:0] core_addr_i,
   input  logic [31:0]           core_wdata_i,
   output logic [31:0]           core_rdata_o,
   output logic                  core_stall_o,
   output logic                  core_fault_o,
   output logic                  core_misaligned_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_ready_i,
   input  logic [31:0]           mem_rdata_i
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]            state_reg;
   logic [7:0]            count_reg;
   logic [2:0]            size_reg;
   logic [1:0]            lane_reg;
   logic                  req_reg;
   logic                  we_reg;
   logic                  fault_reg;
   logic [3:0]            be_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [31:0]           wdata_reg;
   logic [31:0]           rdata_reg;

   logic                  size_illegal;
   logic [1:0]            lane_next;
   logic [3:0]            be_next;
   logic [31:0]           wdata_next;
   logic [31:0]           shifted;
   logic [31:0]           load_next;
   logic                  expired;

`ifdef MISALIGN_TRAP_EN
   logic                  misaligned_reg;
   logic                  misaligned_next;
   assign misaligned_next = (core_size_i[1:0] == 2'b01 && core_addr_i[0]) ||
                            (core_size_i[1:0] == 2'b10 && core_addr_i[1:0] != 2'b00);
   assign core_misaligned_o = misaligned_reg;
`else
   assign core_misaligned_o = 1'b0;
`endif

   // Lane offset is the address rounded down to the access granularity.
   always_comb begin
      size_illegal = (core_size_i == 3'b011) || (core_size_i[2:1] == 2'b11);
      lane_next    = 2'b00;
      be_next      = 4'b1111;
      case (core_size_i[1:0])
         2'b00: begin
            lane_next = core_addr_i[1:0];
            be_next   = 4'b0001 << core_addr_i[1:0];
         end
         2'b01: begin
            lane_next = {core_addr_i[1], 1'b0};
            be_next   = 4'b0011 << {core_addr_i[1], 1'b0};
         end
         default: ;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wlane
         assign wdata_next[8*gi +: 8] =
            (core_size_i[1:0] == 2'b00) ? core_wdata_i[7:0] :
            (core_size_i[1:0] == 2'b01) ? core_wdata_i[8*(gi%2) +: 8] :
                                          core_wdata_i[8*gi +: 8];
      end
   endgenerate

   assign shifted = mem_rdata_i >> {lane_reg, 3'b000};

   always_comb begin
      case (size_reg)
         3'b000:  load_next = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_next = {24'd0, shifted[7:0]};
         3'b001:  load_next = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_next = {16'd0, shifted[15:0]};
         default: load_next = shifted;
      endcase
   end

   assign expired = (count_reg == TIMEOUT_LAST);

   always_comb begin
      case (state_reg)
         ST_IDLE: core_stall_o = core_req_i;
         ST_BUSY: core_stall_o = 1'b1;
         default: core_stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         size_reg  <= '0;
         lane_reg  <= '0;
         req_reg   <= 1'b0;
         we_reg    <= 1'b0;
         fault_reg <= 1'b0;
         be_reg    <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
`ifdef MISALIGN_TRAP_EN
         misaligned_reg <= 1'b0;
`endif
      end else begin
         fault_reg <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misaligned_reg <= 1'b0;
`endif
         case (state_reg)
            ST_IDLE: begin
               count_reg <= '0;
               if (core_req_i) begin
                  if (size_illegal) begin
                     state_reg <= ST_DONE;
                     fault_reg <= 1'b1;
                  end
`ifdef MISALIGN_TRAP_EN
                  else if (misaligned_next) begin
                     state_reg      <= ST_DONE;
                     misaligned_reg <= 1'b1;
                  end
`endif
                  else begin
                     state_reg <= ST_BUSY;
                     req_reg   <= 1'b1;
                     we_reg    <= core_we_i;
                     size_reg  <= core_size_i;
                     lane_reg  <= lane_next;
                     be_reg    <= be_next;
                     addr_reg  <= {core_addr_i[ADDR_WIDTH-1:2], 2'b00};
                     wdata_reg <= wdata_next;
                  end
               end
            end
            ST_BUSY: begin
               count_reg <= count_reg + 8'd1;
               // Ready on the expiring cycle still completes the access.
               if (mem_ready_i) begin
                  req_reg   <= 1'b0;
                  state_reg <= ST_DONE;
                  if (!we_reg) begin
                     rdata_reg <= load_next;
                  end
               end else if (expired) begin
                  req_reg   <= 1'b0;
                  rdata_reg <= '0;
                  fault_reg <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end
            default: begin
               count_reg <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign core_rdata_o = rdata_reg;
   assign core_fault_o = fault_reg;
   assign mem_req_o    = req_reg;
   assign mem_we_o     = we_reg;
   assign mem_be_o     = be_reg;
   assign mem_addr_o   = addr_reg;
   assign mem_wdata_o  = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed test-plan accesses plus randomized traffic
// checked against an arithmetic reference model of the byte/half/word access rules.
module tb_load_store_unit;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wdata_i;
   logic [31:0] core_rdata_o;
   logic        core_stall_o;
   logic        core_fault_o;
   logic        core_misaligned_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ready_i;
   logic [31:0] mem_rdata_i;

   int          checks = 0;
   int          errors = 0;
   int          txn    = 0;
   logic [31:0] rdata_model = 32'd0;

   load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT), .ADDR_WIDTH(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .core_req_i        (core_req_i),
      .core_we_i         (core_we_i),
      .core_size_i       (core_size_i),
      .core_addr_i       (core_addr_i),
      .core_wdata_i      (core_wdata_i),
      .core_rdata_o      (core_rdata_o),
      .core_stall_o      (core_stall_o),
      .core_fault_o      (core_fault_o),
      .core_misaligned_o (core_misaligned_o),
      .mem_req_o         (mem_req_o),
      .mem_we_o          (mem_we_o),
      .mem_be_o          (mem_be_o),
      .mem_addr_o        (mem_addr_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_ready_i       (mem_ready_i),
      .mem_rdata_i       (mem_rdata_i)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expd);
      end
   endtask

   function automatic int size_bytes(input logic [2:0] s);
      if (s == 3'b010) return 4;
      if (s == 3'b001 || s == 3'b101) return 2;
      return 1;
   endfunction

   // One core access, entered and left on a falling edge. wait_cyc < 0 = never ready.
   task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int wait_cyc);
      int          nb, off, i, exp_busy;
      bit          legal, trap, timeout;
      logic [31:0] exp_be, exp_wd, exp_ld, mask;

      legal = (size == 3'b000) || (size == 3'b001) || (size == 3'b010) ||
              (size == 3'b100) || (size == 3'b101);
      nb     = size_bytes(size);
      off    = ((int'(addr % 4)) / nb) * nb;
      exp_be = ((32'd1 << nb) - 32'd1) << off;
      for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wdata[8*(k % nb) +: 8];
      mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      exp_ld = (rdata >> (8*off)) & mask;
      if (!(size == 3'b100 || size == 3'b101) && nb < 4 && exp_ld[8*nb-1]) exp_ld = exp_ld | ~mask;
`ifdef MISALIGN_TRAP_EN
      trap = legal && ((addr % nb) != 0);
`else
      trap = 1'b0;
`endif
      timeout  = (wait_cyc < 0) || (wait_cyc >= TIMEOUT);
      exp_busy = timeout ? TIMEOUT : wait_cyc + 1;

      $display("txn %0d: we=%0d size=%03b addr=%h wdata=%h mem_rdata=%h wait=%0d",
               txn, we, size, addr, wdata, rdata, wait_cyc);
      txn++;

      core_req_i = 1'b1; core_we_i = we; core_size_i = size;
      core_addr_i = addr; core_wdata_i = wdata;
      #1 check("stall_idle", core_stall_o, 1);
      @(negedge clk);
      if (!legal || trap) begin
         check("noacc_req", mem_req_o, 0);
         check("noacc_fault", core_fault_o, !legal);
         check("noacc_misal", core_misaligned_o, trap);
         check("noacc_stall", core_stall_o, 0);
         check("noacc_rdata", core_rdata_o, rdata_model);
      end else begin
         check("busy_req", mem_req_o, 1);
         check("busy_we", mem_we_o, we);
         check("busy_be", mem_be_o, exp_be);
         check("busy_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
         if (we) check("busy_wdata", mem_wdata_o, exp_wd);
         i = 0;
         while (core_stall_o && i < 300) begin
            mem_ready_i = (i == wait_cyc);
            mem_rdata_i = rdata;
            @(negedge clk);
            i++;
         end
         mem_ready_i = 1'b0;
         mem_rdata_i = $urandom;
         check("busy_cycles", i, exp_busy);
         if (timeout) rdata_model = 32'd0;
         else if (!we) rdata_model = exp_ld;
         check("done_req", mem_req_o, 0);
         check("done_fault", core_fault_o, timeout);
         check("done_rdata", core_rdata_o, rdata_model);
      end
      core_req_i = 1'b0;
      @(negedge clk);
      check("idle_stall", core_stall_o, 0);
      check("idle_fault", core_fault_o, 0);
      check("idle_misal", core_misaligned_o, 0);
   endtask

   initial begin
      logic [2:0] sizes [8];
      int         idx;
      logic [2:0] sz;
      sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

      reset = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'b000;
      core_addr_i = 32'd0; core_wdata_i = 32'd0; mem_ready_i = 1'b0; mem_rdata_i = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_req", mem_req_o, 0);
      check("rst_stall", core_stall_o, 0);
      check("rst_fault", core_fault_o, 0);
      check("rst_rdata", core_rdata_o, 0);
      check("rst_be", mem_be_o, 0);
      reset = 1'b0;
      @(negedge clk);

      access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
      access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0);
      access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1);
      access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 0);
      access(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h5555_5555, 1);
      access(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1111_2222, -1);
      access(1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'h3333_4444, TIMEOUT - 1);
      access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0);
      access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
      access(1'b1, 3'b111, 32'h0000_0100, 32'h0, 32'h0, 0);

      // Reset during the third BUSY cycle abandons the access.
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h300;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1; core_req_i = 1'b0;
      @(negedge clk);
      check("rstbusy_req", mem_req_o, 0);
      check("rstbusy_stall", core_stall_o, 0);
      check("rstbusy_we", mem_we_o, 0);
      check("rstbusy_be", mem_be_o, 0);
      check("rstbusy_addr", mem_addr_o, 0);
      check("rstbusy_wdata", mem_wdata_o, 0);
      check("rstbusy_rdata", core_rdata_o, 0);
      check("rstbusy_fault", core_fault_o, 0);
      rdata_model = 32'd0;
      reset = 1'b0;
      @(negedge clk);
      access(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0, 0);

      for (int n = 0; n < 40; n++) begin
         idx = $urandom_range(0, 10);
         sz  = (idx < 10) ? sizes[idx % 5] : sizes[5 + $urandom_range(0, 2)];
         access(1'($urandom_range(0, 1)), sz, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 4)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
